// File: rtl/divrem_ctrl_pkg.sv
// Shared types and defaults for the divide/remainder sequencer.
package divrem_ctrl_pkg;

    localparam int unsigned LenWordDef = 32;

    // Sequencer states.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StWait  = 3'd2,
        StResp  = 3'd3,
        StDrain = 3'd4
    } state_e;

endpackage

// File: rtl/divrem_sign_fix.sv
// Conditional two's-complement negation of quotient/remainder for signed ops.
// Also used on the operands to form magnitudes: with s1 = dividend sign,
// s2 = dividend sign ^ divisor sign, q negates uq by the divisor sign and r
// negates ur by the dividend sign.
module divrem_sign_fix #(
    parameter int unsigned LEN_WORD = 32
) (
    input  logic                unsig,
    input  logic                s1,
    input  logic                s2,
    input  logic [LEN_WORD-1:0] uq,
    input  logic [LEN_WORD-1:0] ur,
    output logic [LEN_WORD-1:0] q,
    output logic [LEN_WORD-1:0] r
);

    // Quotient flips on differing signs, remainder follows the dividend.
    always_comb begin
        q = uq;
        r = ur;
        if (!unsig && (s1 ^ s2)) begin
            q = ~uq + LEN_WORD'(1);
        end
        if (!unsig && s1) begin
            r = ~ur + LEN_WORD'(1);
        end
    end

endmodule

// File: rtl/divrem_ctrl.sv
// Sequencer between the execute stage and a pipelined unsigned divider.
// Resolves div-by-zero and signed overflow locally, keeps a one-entry result
// cache so a DIV/REM pair on the same operands uses a single divider pass.
module divrem_ctrl
    import divrem_ctrl_pkg::*;
#(
    parameter int unsigned LEN_WORD  = LenWordDef,
    parameter int unsigned USE_CACHE = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                order,
    output logic                accepted,
    output logic                done,
    input  logic [LEN_WORD-1:0] rs1,
    input  logic [LEN_WORD-1:0] rs2,
    input  logic                unsig,
    input  logic                rem_flag,
    input  logic                flush,
    output logic [LEN_WORD-1:0] rd,
    output logic                div_order,
    input  logic                div_accepted,
    input  logic                div_done,
    output logic [LEN_WORD-1:0] div_rs1,
    output logic [LEN_WORD-1:0] div_rs2,
    input  logic [LEN_WORD-1:0] div_quo,
    input  logic [LEN_WORD-1:0] div_rem
);

    localparam logic [LEN_WORD-1:0] ALL_ONES = '1;
    localparam logic [LEN_WORD-1:0] INT_MIN  = {1'b1, {(LEN_WORD - 1){1'b0}}};

    state_e state_q, state_d;
    // Set for the cycle after accept, when the registered operands are classified.
    logic                pend_q, pend_d;
    logic [LEN_WORD-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic                unsig_q, unsig_d, rem_q, rem_d;
    logic [LEN_WORD-1:0] quo_q, quo_d, rmd_q, rmd_d;
    logic [LEN_WORD-1:0] rd_q, rd_d;
    logic                c_valid_q, c_valid_d, c_unsig_q, c_unsig_d;
    logic [LEN_WORD-1:0] c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d;
    logic [LEN_WORD-1:0] c_quo_q, c_quo_d, c_rmd_q, c_rmd_d;

    logic [LEN_WORD-1:0] fix_q, fix_r;
    logic                is_div0, is_ovf, hit;

    divrem_sign_fix #(.LEN_WORD(LEN_WORD)) u_mag (
        .unsig (unsig_q),
        .s1    (rs1_q[LEN_WORD-1]),
        .s2    (rs1_q[LEN_WORD-1] ^ rs2_q[LEN_WORD-1]),
        .uq    (rs2_q),
        .ur    (rs1_q),
        .q     (div_rs2),
        .r     (div_rs1)
    );

    divrem_sign_fix #(.LEN_WORD(LEN_WORD)) u_fix (
        .unsig (unsig_q),
        .s1    (rs1_q[LEN_WORD-1]),
        .s2    (rs2_q[LEN_WORD-1]),
        .uq    (div_quo),
        .ur    (div_rem),
        .q     (fix_q),
        .r     (fix_r)
    );

    // Operand classification on the registered request.
    always_comb begin
        is_div0 = (rs2_q == '0);
        is_ovf  = !unsig_q && (rs1_q == INT_MIN) && (rs2_q == ALL_ONES);
        hit     = (USE_CACHE != 0) && c_valid_q && (c_rs1_q == rs1_q) &&
                  (c_rs2_q == rs2_q) && (c_unsig_q == unsig_q);
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        unsig_d   = unsig_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        rd_d      = rd_q;
        c_valid_d = c_valid_q;
        c_unsig_d = c_unsig_q;
        c_rs1_d   = c_rs1_q;
        c_rs2_d   = c_rs2_q;
        c_quo_d   = c_quo_q;
        c_rmd_d   = c_rmd_q;
        accepted  = 1'b0;
        done      = 1'b0;
        div_order = 1'b0;
        rd        = rd_q;

        unique case (state_q)
            StIdle: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (!flush) begin
                        if (is_div0) begin
                            quo_d   = ALL_ONES;
                            rmd_d   = rs1_q;
                            state_d = StResp;
                        end else if (is_ovf) begin
                            quo_d   = INT_MIN;
                            rmd_d   = '0;
                            state_d = StResp;
                        end else if (hit) begin
                            quo_d   = c_quo_q;
                            rmd_d   = c_rmd_q;
                            state_d = StResp;
                        end else begin
                            state_d = StIssue;
                        end
                    end
                end else if (order && !flush) begin
                    accepted = 1'b1;
                    pend_d   = 1'b1;
                    rs1_d    = rs1;
                    rs2_d    = rs2;
                    unsig_d  = unsig;
                    rem_d    = rem_flag;
                end
            end
            StIssue: begin
                div_order = 1'b1;
                if (div_accepted) begin
                    state_d = flush ? StDrain : StWait;
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (div_done) begin
                    if (flush) begin
                        state_d = StIdle;
                    end else begin
                        quo_d   = fix_q;
                        rmd_d   = fix_r;
                        state_d = StResp;
                        if (USE_CACHE != 0) begin
                            c_valid_d = 1'b1;
                            c_unsig_d = unsig_q;
                            c_rs1_d   = rs1_q;
                            c_rs2_d   = rs2_q;
                            c_quo_d   = fix_q;
                            c_rmd_d   = fix_r;
                        end
                    end
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StResp: begin
                state_d = StIdle;
                if (!flush) begin
                    done = 1'b1;
                    rd   = rem_q ? rmd_q : quo_q;
                    rd_d = rd;
                end
            end
            StDrain: begin
                if (div_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            pend_q    <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            unsig_q   <= 1'b0;
            rem_q     <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
            rd_q      <= '0;
            c_valid_q <= 1'b0;
            c_unsig_q <= 1'b0;
            c_rs1_q   <= '0;
            c_rs2_q   <= '0;
            c_quo_q   <= '0;
            c_rmd_q   <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            unsig_q   <= unsig_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            rd_q      <= rd_d;
            c_valid_q <= c_valid_d;
            c_unsig_q <= c_unsig_d;
            c_rs1_q   <= c_rs1_d;
            c_rs2_q   <= c_rs2_d;
            c_quo_q   <= c_quo_d;
            c_rmd_q   <= c_rmd_d;
        end
    end

endmodule

// File: tb/tb_divrem_ctrl.sv
// Directed bench for divrem_ctrl with a fixed-latency unsigned divider model.
module tb_divrem_ctrl;

    localparam int DivLat = 8;

    logic        clk = 1'b0;
    logic        rstn, order, accepted, done, unsig, rem_flag, flush;
    logic [31:0] rs1, rs2, rd;
    logic        div_order, div_accepted, div_done;
    logic [31:0] div_rs1, div_rs2, div_quo, div_rem;

    logic        stall, m_busy;
    int          m_cnt;
    logic [31:0] m_a, m_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    divrem_ctrl #(.LEN_WORD(32), .USE_CACHE(1)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .order        (order),
        .accepted     (accepted),
        .done         (done),
        .rs1          (rs1),
        .rs2          (rs2),
        .unsig        (unsig),
        .rem_flag     (rem_flag),
        .flush        (flush),
        .rd           (rd),
        .div_order    (div_order),
        .div_accepted (div_accepted),
        .div_done     (div_done),
        .div_rs1      (div_rs1),
        .div_rs2      (div_rs2),
        .div_quo      (div_quo),
        .div_rem      (div_rem)
    );

    assign div_accepted = div_order & ~m_busy & ~stall;

    // Divider model: one op at a time, result DivLat cycles after acceptance.
    always @(posedge clk) begin
        if (!rstn) begin
            m_busy   <= 1'b0;
            m_cnt    <= 0;
            m_a      <= '0;
            m_b      <= '0;
            div_done <= 1'b0;
            div_quo  <= '0;
            div_rem  <= '0;
        end else begin
            div_done <= 1'b0;
            if (div_order && div_accepted) begin
                m_busy <= 1'b1;
                m_cnt  <= DivLat;
                m_a    <= div_rs1;
                m_b    <= div_rs2;
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy   <= 1'b0;
                    div_done <= 1'b1;
                    div_quo  <= (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b;
                    div_rem  <= (m_b == 0) ? m_a : m_a % m_b;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request, hold order until accepted, then wait for done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic u,
                          input logic rf, output logic [31:0] res, output int lat,
                          output int kdd, output bit saw, output int wait_c,
                          output bit dwait);
        rs1 = a; rs2 = b; unsig = u; rem_flag = rf; order = 1'b1;
        res = '0; lat = 0; kdd = 0; saw = 1'b0; wait_c = 0; dwait = 1'b0;
        #1;
        while (!accepted && wait_c < 100) begin
            if (done) dwait = 1'b1;
            @(negedge clk);
            #1;
            wait_c++;
        end
        @(negedge clk);
        order = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            #1;
            if (div_order) saw = 1'b1;
            if (div_done) kdd = k;
            if (done) begin
                lat = k;
                res = rd;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // kind 0: resolved locally (done at T+2, no divider), kind 1: divider pass.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic u, input logic rf, input logic [31:0] exp_rd,
                         input int kind);
        logic [31:0] res;
        int          lat, kdd, wait_c;
        bit          saw, dwait;
        run_op(a, b, u, rf, res, lat, kdd, saw, wait_c, dwait);
        chk({tag, "_rd"}, res, exp_rd);
        if (kind == 0) begin
            chk({tag, "_lat"}, lat, 2);
            chk({tag, "_noord"}, {31'b0, saw}, 0);
        end else begin
            chk({tag, "_ord"}, {31'b0, saw}, 1);
            chk({tag, "_lat"}, lat, kdd + 1);
        end
        #1;
        chk({tag, "_hold"}, rd, exp_rd);
        chk({tag, "_pulse"}, {31'b0, done}, 0);
    endtask

    task automatic wait_div_taken(input string tag);
        bit got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (div_order && div_accepted) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_taken"}, {31'b0, got}, 1);
        @(negedge clk);
    endtask

    initial begin : main
        logic [31:0] res;
        int          lat, kdd, wait_c;
        bit          saw, dwait;

        rstn = 1'b0; order = 1'b0; flush = 1'b0; stall = 1'b0;
        rs1 = '0; rs2 = '0; unsig = 1'b0; rem_flag = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_div_order", {31'b0, div_order}, 0);
        chk("rst_rd", rd, 0);
        chk("rst_div_rs1", div_rs1, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Cache pair and sign handling.
        do_op("div_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1);
        do_op("rem_100_7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 0);
        do_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'hFFFF_FFFD, 1);
        do_op("rem_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 0);
        do_op("divu_fff9_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'h7FFF_FFFC, 1);
        do_op("remu_fff9_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'd1, 0);
        do_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'hFFFF_FFFD, 1);
        do_op("rem_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'd1, 0);

        // Locally resolved cases.
        do_op("div_5_0", 32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 0);
        do_op("rem_5_0", 32'd5, 32'd0, 1'b0, 1'b1, 32'd5, 0);
        do_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, 0);
        do_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 0);
        do_op("divu_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 1);
        do_op("remu_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 0);

        // Flush while waiting on the divider, then a held request during drain.
        rs1 = 32'd20; rs2 = 32'd7; unsig = 1'b0; rem_flag = 1'b0; order = 1'b1;
        #1;
        chk("fw_acc", {31'b0, accepted}, 1);
        @(negedge clk);
        order = 1'b0;
        wait_div_taken("fw");
        flush = 1'b1;
        #1;
        chk("fw_flush_done", {31'b0, done}, 0);
        @(negedge clk);
        flush = 1'b0;
        run_op(32'd9, 32'd3, 1'b0, 1'b0, res, lat, kdd, saw, wait_c, dwait);
        chk("fw_held_wait", {31'b0, wait_c >= 4}, 1);
        chk("fw_no_done", {31'b0, dwait}, 0);
        chk("fw_div_9_3", res, 32'd3);
        chk("fw_div_9_3_ord", {31'b0, saw}, 1);
        do_op("fw_rem_20_7", 32'd20, 32'd7, 1'b0, 1'b1, 32'd6, 1);

        // Flush while the divider is stalling the request.
        stall = 1'b1;
        rs1 = 32'd50; rs2 = 32'd5; unsig = 1'b0; rem_flag = 1'b0; order = 1'b1;
        #1;
        chk("fi_acc", {31'b0, accepted}, 1);
        @(negedge clk);
        order = 1'b0;
        for (int k = 0; k < 10 && !div_order; k++) @(negedge clk);
        #1;
        chk("fi_ord", {31'b0, div_order}, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fi_idle_ord", {31'b0, div_order}, 0);
        chk("fi_no_done", {31'b0, done}, 0);
        stall = 1'b0;
        order = 1'b1;
        flush = 1'b1;
        #1;
        chk("of_same_cycle", {31'b0, accepted}, 0);
        @(negedge clk);
        flush = 1'b0;
        order = 1'b0;
        do_op("fi_div_50_5", 32'd50, 32'd5, 1'b0, 1'b0, 32'd10, 1);

        // Reset in the middle of a divider wait.
        do_op("r_div_1000_10", 32'd1000, 32'd10, 1'b0, 1'b0, 32'd100, 1);
        rs1 = 32'd33; rs2 = 32'd4; unsig = 1'b0; rem_flag = 1'b0; order = 1'b1;
        #1;
        chk("r_acc", {31'b0, accepted}, 1);
        @(negedge clk);
        order = 1'b0;
        wait_div_taken("r");
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        chk("r_done", {31'b0, done}, 0);
        chk("r_div_order", {31'b0, div_order}, 0);
        chk("r_rd", rd, 0);
        chk("r_accepted", {31'b0, accepted}, 0);
        chk("r_div_rs1", div_rs1, 0);
        chk("r_div_rs2", div_rs2, 0);
        rstn = 1'b1;
        @(negedge clk);
        do_op("r_rem_1000_10", 32'd1000, 32'd10, 1'b0, 1'b1, 32'd0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
